// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, LSU state enum and load-extension helper for dmem_lsu
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } dmem_state_t;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  byte_off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {byte_off, 3'b000});
        h = byte_off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - DEPTH x 32 data RAM, byte-enabled synchronous write, registered read, no reset
module dmem_ram #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[index];
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit over internal RAM; counters enabled by DMEM_ACCESS_COUNT_EN
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic [31:0] fault_addr,
    output logic [31:0] load_count,
    output logic [31:0] store_count
);

    dmem_state_t state, state_nxt;
    logic        fault;
    logic        do_store;
    logic        do_load;
    logic [3:0]  be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    always_comb begin
        fault      = 1'b0;
        misaligned = 1'b0;
        do_store   = 1'b0;
        do_load    = 1'b0;
        stall      = 1'b0;
        state_nxt  = state;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = addr[0];
            F3_W:    fault = |addr[1:0];
            F3_BU:   fault = mem_write;
            F3_HU:   fault = mem_write | addr[0];
            default: fault = 1'b1;
        endcase
        case (state)
            IDLE: begin
                misaligned = (mem_read | mem_write) & fault;
                do_store   = mem_write & ~fault;
                do_load    = mem_read & ~mem_write & ~fault;
                stall      = do_load;
                if (do_load) state_nxt = LOAD_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Store lanes: data is replicated so the byte enables alone select the target bytes.
    always_comb begin
        be        = 4'b1111;
        ram_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr[1:0];
                ram_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (do_store),
        .be    (be),
        .re    (do_load),
        .index (addr[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            f3_q       <= F3_B;
            off_q      <= 2'b00;
            fault_addr <= 32'h0;
        end else begin
            state <= state_nxt;
            if (do_load) begin
                f3_q  <= funct3;
                off_q <= addr[1:0];
            end
            if (misaligned) fault_addr <= addr;
        end
    end

    assign rdata = (state == LOAD_WAIT) ? load_extend(ram_q, f3_q, off_q) : 32'h0;

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count  <= 32'h0;
            store_count <= 32'h0;
        end else begin
            if (state == LOAD_WAIT) load_count <= load_count + 32'd1;
            if (do_store) store_count <= store_count + 32'd1;
        end
    end
`else
    assign load_count  = 32'h0;
    assign store_count = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu: byte-level memory model plus directed literals
module tb_dmem_lsu;

    localparam int MEMB = 4 * 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic [31:0] fault_addr;
    logic [31:0] load_count;
    logic [31:0] store_count;

    int n_cmp = 0;
    int n_err = 0;

    dmem_lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .stall       (stall),
        .misaligned  (misaligned),
        .fault_addr  (fault_addr),
        .load_count  (load_count),
        .store_count (store_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte-addressed memory and a pending-load flag
    logic [7:0]  mbytes [MEMB];
    bit          known  [MEMB];
    bit          busy = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic [2:0]  p_f3 = 3'b000;
    logic [31:0] m_fault_addr = 32'h0;
    logic [31:0] m_lc = 32'h0;
    logic [31:0] m_sc = 32'h0;

    function automatic bit is_fault(input logic [2:0] f3, input logic [31:0] a, input logic w);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return a[1:0] != 2'b00;
            3'b100:  return w;
            3'b101:  return w || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_known();
        int n = nbytes(p_f3);
        for (int i = 0; i < n; i++)
            if (!known[(p_addr + i) % MEMB]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_rdata();
        int n;
        logic [31:0] v;
        if (!busy) return 32'h0;
        n = nbytes(p_f3);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(mbytes[(p_addr + i) % MEMB]) << (8 * i));
        if (n == 1 && !p_f3[2] && v[7])  v = v | 32'hFFFFFF00;
        if (n == 2 && !p_f3[2] && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
            m_fault_addr = 32'h0;
            m_lc = 32'h0;
            m_sc = 32'h0;
        end else if (busy) begin
            busy = 1'b0;
            m_lc = m_lc + 1;
        end else if (mem_read || mem_write) begin
            if (is_fault(funct3, addr, mem_write)) begin
                m_fault_addr = addr;
            end else if (mem_write) begin
                for (int i = 0; i < nbytes(funct3); i++) begin
                    mbytes[(addr + i) % MEMB] = wdata[8*i +: 8];
                    known[(addr + i) % MEMB] = 1'b1;
                end
                m_sc = m_sc + 1;
            end else begin
                busy = 1'b1;
                p_addr = addr;
                p_f3 = funct3;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall", 32'(stall), 32'(!busy && mem_read && !mem_write && !is_fault(funct3, addr, mem_write)));
            chk("misaligned", 32'(misaligned), 32'(!busy && (mem_read || mem_write) && is_fault(funct3, addr, mem_write)));
            if (!busy || model_known()) chk("rdata", rdata, model_rdata());
            chk("fault_addr", fault_addr, m_fault_addr);
`ifdef DMEM_ACCESS_COUNT_EN
            chk("load_count", load_count, m_lc);
            chk("store_count", store_count, m_sc);
`else
            chk("load_count", load_count, 32'h0);
            chk("store_count", store_count, 32'h0);
`endif
        end
    end

    task automatic apply(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        mem_read = r;
        mem_write = w;
        funct3 = f3;
        addr = a;
        wdata = d;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        apply(1'b0, 1'b1, f3, a, d);
    endtask

    task automatic load_lit(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp);
        apply(1'b1, 1'b0, f3, a, 32'h0);
        @(negedge clk);
        chk({name, "_stall1"}, 32'(stall), 32'h1);
        apply(1'b1, 1'b0, f3, a, 32'h0);
        @(negedge clk);
        chk({name, "_stall2"}, 32'(stall), 32'h0);
        chk({name, "_rdata"}, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_load_count", load_count, 32'h0);
        chk("rst_store_count", store_count, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        store(3'b010, 32'h10, 32'hDEADBEEF);
        load_lit("lw10", 3'b010, 32'h10, 32'hDEADBEEF);
        store(3'b000, 32'h13, 32'h00000080);
        load_lit("lb13", 3'b000, 32'h13, 32'hFFFFFF80);
        load_lit("lbu13", 3'b100, 32'h13, 32'h00000080);
        load_lit("lw10b", 3'b010, 32'h10, 32'h80ADBEEF);
        store(3'b001, 32'h22, 32'h00008001);
        load_lit("lh22", 3'b001, 32'h22, 32'hFFFF8001);
        load_lit("lhu22", 3'b101, 32'h22, 32'h00008001);

        apply(1'b1, 1'b0, 3'b010, 32'h21, 32'h0);
        @(negedge clk);
        chk("lw21_mis", 32'(misaligned), 32'h1);
        chk("lw21_stall", 32'(stall), 32'h0);
        apply(1'b1, 1'b0, 3'b001, 32'h23, 32'h0);
        @(negedge clk);
        chk("lw21_fault_addr", fault_addr, 32'h21);
        chk("lh23_mis", 32'(misaligned), 32'h1);
        apply(1'b1, 1'b0, 3'b011, 32'h30, 32'h0);
        @(negedge clk);
        chk("lh23_fault_addr", fault_addr, 32'h23);
        chk("f3_011_mis", 32'(misaligned), 32'h1);
        apply(1'b0, 1'b1, 3'b100, 32'h11, 32'h000000FF);
        @(negedge clk);
        chk("sbu_mis", 32'(misaligned), 32'h1);
        idle();
        @(negedge clk);
        chk("sbu_fault_addr", fault_addr, 32'h11);
        load_lit("lw10c", 3'b010, 32'h10, 32'h80ADBEEF);

        apply(1'b1, 1'b1, 3'b010, 32'h60, 32'h11223344);
        @(negedge clk);
        chk("rw_stall", 32'(stall), 32'h0);
        load_lit("lw60", 3'b010, 32'h60, 32'h11223344);
        store(3'b010, 32'h460, 32'hCAFEF00D);
        load_lit("lw60alias", 3'b010, 32'h60, 32'hCAFEF00D);

        store(3'b010, 32'h40, 32'h55AA1234);
        apply(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("rstlw_stall", 32'(stall), 32'h0);
        chk("rstlw_rdata", rdata, 32'h0);
        chk("rstlw_load_count", load_count, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        load_lit("lw40", 3'b010, 32'h40, 32'h55AA1234);
        store(3'b000, 32'h50, 32'h000000AB);
        store(3'b001, 32'h54, 32'h00001234);
        store(3'b010, 32'h58, 32'h0BADCAFE);
        load_lit("lw58", 3'b010, 32'h58, 32'h0BADCAFE);
        idle();
        @(negedge clk);
`ifdef DMEM_ACCESS_COUNT_EN
        chk("cnt_store", store_count, 32'd3);
        chk("cnt_load", load_count, 32'd2);
`else
        chk("cnt_store", store_count, 32'd0);
        chk("cnt_load", load_count, 32'd0);
`endif
        idle();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Data-memory load/store unit directly downstream of the ALU: takes the ALU result as the byte address and RD2 as store data, and performs RV32I byte, halfword and word loads and stores against an internal synchronous-read RAM. Loads take two cycles, so the unit raises `stall` for the first cycle. It sign- or zero-extends load data, generates byte enables for stores, and detects misaligned or illegal accesses. Its output feeds the result/write-back mux.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; power of two.
- `AW`, $clog2(DEPTH): word-index width; derived, not overridden.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `mem_read` in 1: load request for the current instruction.
- `mem_write` in 1: store request for the current instruction.
- `funct3` in 3: access size/sign (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (RD2).
- `rdata` out 32: extended load result, valid in LOAD_WAIT.
- `stall` out 1: CPU must hold PC and pipeline inputs.
- `misaligned` out 1: combinational fault flag for the current request.
- `fault_addr` out 32: address of the most recent faulting request.
- `load_count`, `store_count` out 32: completed access counters (see Configuration).

## Operation
- States: IDLE, LOAD_WAIT.
- Word index is `addr[AW+1:2]`. Upper address bits are ignored, so out-of-range addresses alias (wrap).
- Fault conditions:
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]`!=0.
  - `funct3` of 011, 110 or 111 on any access.
  - Stores with `funct3` of 100 or 101.
- A faulting request performs no RAM access and no state change.
  - `misaligned`=1 while the request is presented.
  - `fault_addr` captures `addr` at the clock edge.
- IDLE with `mem_write`=1 and no fault: write at the edge with byte enables.
  - SB: byte `addr[1:0]`, data `wdata[7:0]` replicated.
  - SH: half `addr[1]`, data `wdata[15:0]` replicated.
  - SW: all four bytes.
  - State stays IDLE; `stall`=0.
- IDLE with `mem_read`=1, `mem_write`=0 and no fault: RAM read issued.
  - `stall`=1 combinationally.
  - `funct3` and `addr[1:0]` are latched.
  - Next state is LOAD_WAIT.
- `mem_read` and `mem_write` both 1: the write wins and the read is ignored.
- LOAD_WAIT:
  - `stall`=0.
  - `rdata` = lane selected by the latched `addr[1:0]`, extended per the latched `funct3` (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word).
  - Requests presented in LOAD_WAIT are ignored (the CPU is re-presenting the same load); no fault is recorded.
  - Next state is always IDLE.
- In IDLE, `rdata`=0.

## Timing
- Store latency: 1 cycle (written at the edge where it is presented).
- Load latency: 2 cycles (`stall` high for cycle 1, data in cycle 2).
- Store-then-load to the same word on consecutive instructions returns the new data; the write completes at the first edge.
- Reset values:
  - State IDLE.
  - `stall`=0, `rdata`=0, `fault_addr`=0, counters 0.
  - `misaligned` is a function of the inputs.
  - RAM contents are not reset.
- Reset asserted during LOAD_WAIT: return to IDLE immediately; the load is abandoned and the counter is not incremented.

## Configuration
- `DMEM_ACCESS_COUNT_EN` defined:
  - `load_count` increments on each LOAD_WAIT cycle.
  - `store_count` increments on each accepted store.
  - Both wrap at 2^32.
- Not defined: both counters are tied to 0 and the counter registers are absent; ports remain.

## Structure
- Package `dmem_pkg` holds:
  - `funct3` localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum `dmem_state_t` (IDLE, LOAD_WAIT).
  - Function `load_extend(word, funct3, byte_off)`.
- One sub-module, `dmem_ram`: `DEPTH`x32 array with synchronous write, 4-bit byte enable and synchronous read (registered output); no reset.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10: `stall`=1 for one cycle, then `rdata`=0xDEADBEEF.
- SB 0x80 to 0x13, then LB 0x13 gives 0xFFFFFF80 and LBU 0x13 gives 0x00000080; bytes 0x10..0x12 are unchanged.
- SH 0x8001 to 0x22; LH 0x22 gives 0xFFFF8001, LHU 0x22 gives 0x00008001.
- LW 0x21: `misaligned`=1, `stall`=0, `fault_addr`=0x21, no state change. LH 0x23 and `funct3`=011 also fault.
- Assert `rst_n` low during LOAD_WAIT: `stall`=0, `rdata`=0, state IDLE. A subsequent LW returns the previously stored word (RAM is not cleared).
- With `DMEM_ACCESS_COUNT_EN`: 3 stores and 2 loads give `store_count`=3 and `load_count`=2. Without the macro, both read 0.
